// File: rtl/sa_pkg.sv
// Shared types and constants for the register-file to systolic-array operand path.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        BIAS,
        COMPUTE,
        ACK
    } state_t;

    localparam int OP_FLATTEN = 0;
    localparam int OP_SEL     = 1;
    localparam int OP_RELU    = 2;

    localparam logic CONV = 1'b0;
    localparam logic MUL  = 1'b1;

    localparam int SA_WIDTH      = 8;
    localparam int SA_DATA_WIDTH = 8;

    typedef logic [SA_DATA_WIDTH-1:0] elem_t;
    typedef elem_t [SA_WIDTH-1:0]     row_t;

endpackage

// File: rtl/sa_operand_loader.sv
// Purpose: shadows weights/bias/geometry, preloads weight rows bottom-first, then bias, then launches the array.
// Latency: first weight row 1 cycle after start; start-to-done minimum Heff+3 cycles.
// Backpressure: none; pulses arriving in the wrong state are dropped and latch overrun_od.
module sa_operand_loader
    import sa_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          weight_iv,
    input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]  weight_id,
    input  logic                                          bias_iv,
    input  logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]  bias_id,
    input  logic                                          layer_info_iv,
    input  logic [3:0]                                    weight_height_id,
    input  logic [3:0]                                    weight_width_id,
    input  logic [3:0]                                    bias_width_id,
    input  logic [2:0]                                    op_id,
    input  logic                                          start_iv,
    output logic                                          sa_w_ov,
    output logic [WIDTH-1:0][DATA_WIDTH-1:0]              sa_w_row_od,
    output logic                                          sa_bias_ov,
    output logic [WIDTH-1:0][DATA_WIDTH-1:0]              sa_bias_od,
    output logic                                          sa_start_ov,
    input  logic                                          sa_done_iv,
    output logic                                          done_od,
    output logic                                          busy_od,
    output logic                                          overrun_od
);

    localparam int CW = $clog2(HEIGHT) + 1;

    state_t                                        r_state;
    state_t                                        w_next;
    logic [CW-1:0]                                 r_row_cnt;
    logic [CW-1:0]                                 w_row_cnt_nxt;
    logic [CW-1:0]                                 w_row_idx;
    logic [CW-1:0]                                 w_heff;
    logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]  r_weight;
    logic [HEIGHT-1:0][WIDTH-1:0][DATA_WIDTH-1:0]  w_weight;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]              r_bias0;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]              w_bias0;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]              w_row;
    logic [WIDTH-1:0][DATA_WIDTH-1:0]              w_bias_vec;
    logic [3:0]                                    r_wh, r_ww, r_bw;
    logic [3:0]                                    w_wh, w_ww, w_bw;
    logic                                          r_op_sel;
    logic                                          w_op_sel;
    logic                                          w_cap_ok;
    logic                                          w_overrun;
    logic                                          w_unused;

    // Only bias row 0 and the op_sel bit affect what this block emits.
    assign w_unused = ^{bias_id[HEIGHT-1:1], op_id[OP_RELU], op_id[OP_FLATTEN]};

    // Bypass lets a capture pulse coincident with start feed that same run.
    assign w_cap_ok = (r_state != PRELOAD);
    assign w_weight = (weight_iv && w_cap_ok) ? weight_id : r_weight;
    assign w_bias0  = (bias_iv && w_cap_ok) ? bias_id[0] : r_bias0;
    assign w_wh     = (layer_info_iv && w_cap_ok) ? weight_height_id : r_wh;
    assign w_ww     = (layer_info_iv && w_cap_ok) ? weight_width_id : r_ww;
    assign w_bw     = (layer_info_iv && w_cap_ok) ? bias_width_id : r_bw;
    assign w_op_sel = (layer_info_iv && w_cap_ok) ? op_id[OP_SEL] : r_op_sel;

    assign w_heff = (32'(w_wh) > 32'(HEIGHT)) ? CW'(HEIGHT) : CW'(w_wh);

    assign w_overrun = ((r_state == PRELOAD) && (weight_iv || bias_iv || layer_info_iv))
                     || (start_iv && (r_state != IDLE));

    // Row counter holds how many rows remain after the one being loaded.
    always_comb begin
        w_next        = r_state;
        w_row_idx     = '0;
        w_row_cnt_nxt = r_row_cnt;
        case (r_state)
            IDLE: begin
                if (start_iv) begin
                    if (w_heff == '0) begin
                        w_next = BIAS;
                    end else begin
                        w_next        = PRELOAD;
                        w_row_idx     = w_heff - 1'b1;
                        w_row_cnt_nxt = w_heff - 1'b1;
                    end
                end
            end
            PRELOAD: begin
                if (r_row_cnt == '0) begin
                    w_next = BIAS;
                end else begin
                    w_row_idx     = r_row_cnt - 1'b1;
                    w_row_cnt_nxt = r_row_cnt - 1'b1;
                end
            end
            BIAS:    w_next = COMPUTE;
            COMPUTE: if (sa_done_iv) w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_row = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            if (CW'(i) == w_row_idx) w_row = w_weight[i];
        end
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= int'(w_ww)) w_row[j] = '0;
        end
    end

    always_comb begin
        w_bias_vec = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (w_op_sel == CONV) begin
                w_bias_vec[j] = w_bias0[0];
            end else if (j < int'(w_bw)) begin
                w_bias_vec[j] = w_bias0[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_row_cnt   <= '0;
            r_weight    <= '0;
            r_bias0     <= '0;
            r_wh        <= '0;
            r_ww        <= '0;
            r_bw        <= '0;
            r_op_sel    <= 1'b0;
            sa_w_ov     <= 1'b0;
            sa_w_row_od <= '0;
            sa_bias_ov  <= 1'b0;
            sa_bias_od  <= '0;
            sa_start_ov <= 1'b0;
            done_od     <= 1'b0;
            busy_od     <= 1'b0;
            overrun_od  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_row_cnt   <= w_row_cnt_nxt;
            r_weight    <= w_weight;
            r_bias0     <= w_bias0;
            r_wh        <= w_wh;
            r_ww        <= w_ww;
            r_bw        <= w_bw;
            r_op_sel    <= w_op_sel;
            sa_w_ov     <= (w_next == PRELOAD);
            sa_bias_ov  <= (w_next == BIAS);
            sa_start_ov <= (r_state == BIAS);
            done_od     <= (w_next == ACK);
            busy_od     <= (w_next != IDLE);
            if (w_next == PRELOAD) sa_w_row_od <= w_row;
            if (w_next == BIAS)    sa_bias_od  <= w_bias_vec;
            if (w_overrun)         overrun_od  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa_operand_loader.sv
// Scoreboarded bench for sa_operand_loader: expected rows/bias queued at start, popped as the DUT emits them.
module tb_sa_operand_loader;
    import sa_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 weight_iv;
    logic [7:0][7:0][7:0] weight_id;
    logic                 bias_iv;
    logic [7:0][7:0][7:0] bias_id;
    logic                 layer_info_iv;
    logic [3:0]           weight_height_id;
    logic [3:0]           weight_width_id;
    logic [3:0]           bias_width_id;
    logic [2:0]           op_id;
    logic                 start_iv;
    logic                 sa_w_ov;
    row_t                 sa_w_row_od;
    logic                 sa_bias_ov;
    row_t                 sa_bias_od;
    logic                 sa_start_ov;
    logic                 sa_done_iv;
    logic                 done_od;
    logic                 busy_od;
    logic                 overrun_od;

    int   errors = 0;
    int   checks = 0;
    row_t exp_rows[$];
    row_t exp_bias[$];
    row_t last_row;
    row_t last_bias;

    logic [7:0] mw[8][8];
    logic [7:0] mb[8];
    int         m_ww;
    int         m_bw;
    logic       m_op;

    sa_operand_loader #(.WIDTH(8), .HEIGHT(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .weight_iv(weight_iv), .weight_id(weight_id),
        .bias_iv(bias_iv), .bias_id(bias_id),
        .layer_info_iv(layer_info_iv),
        .weight_height_id(weight_height_id), .weight_width_id(weight_width_id),
        .bias_width_id(bias_width_id), .op_id(op_id),
        .start_iv(start_iv),
        .sa_w_ov(sa_w_ov), .sa_w_row_od(sa_w_row_od),
        .sa_bias_ov(sa_bias_ov), .sa_bias_od(sa_bias_od),
        .sa_start_ov(sa_start_ov), .sa_done_iv(sa_done_iv),
        .done_od(done_od), .busy_od(busy_od), .overrun_od(overrun_od)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (sa_w_ov === 1'b1) begin
            checks++;
            if (exp_rows.size() == 0) begin
                errors++;
                $display("FAIL w_row: unexpected row %h, none expected", sa_w_row_od);
            end else begin
                row_t e;
                e = exp_rows.pop_front();
                if (sa_w_row_od !== e) begin
                    errors++;
                    $display("FAIL w_row: got %h want %h", sa_w_row_od, e);
                end
            end
        end
        if (sa_bias_ov === 1'b1) begin
            checks++;
            if (exp_bias.size() == 0) begin
                errors++;
                $display("FAIL bias: unexpected bias %h, none expected", sa_bias_od);
            end else begin
                row_t e;
                e = exp_bias.pop_front();
                if (sa_bias_od !== e) begin
                    errors++;
                    $display("FAIL bias: got %h want %h", sa_bias_od, e);
                end
            end
        end
    end

    task automatic drive_bus();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                weight_id[i][j] = mw[i][j];
        bias_id = '0;
        for (int j = 0; j < 8; j++) bias_id[0][j] = mb[j];
    endtask

    task automatic load(input int h, input int ww, input int bw, input logic op_sel);
        drive_bus();
        weight_height_id = 4'(h);
        weight_width_id  = 4'(ww);
        bias_width_id    = 4'(bw);
        op_id            = {1'b0, op_sel, 1'b0};
        m_ww = ww;
        m_bw = bw;
        m_op = op_sel;
        weight_iv = 1'b1; bias_iv = 1'b1; layer_info_iv = 1'b1;
        @(negedge clk);
        weight_iv = 1'b0; bias_iv = 1'b0; layer_info_iv = 1'b0;
    endtask

    task automatic push_expect(input int heff);
        row_t r;
        for (int i = heff - 1; i >= 0; i--) begin
            for (int j = 0; j < 8; j++) r[j] = (j < m_ww) ? mw[i][j] : 8'h00;
            exp_rows.push_back(r);
            last_row = r;
        end
        for (int j = 0; j < 8; j++) begin
            if (m_op == CONV) r[j] = mb[0];
            else              r[j] = (j < m_bw) ? mb[j] : 8'h00;
        end
        exp_bias.push_back(r);
        last_bias = r;
    endtask

    task automatic run(input int heff, input int dly, input bit inject);
        start_iv = 1'b1;
        @(negedge clk);
        start_iv = 1'b0; weight_iv = 1'b0; bias_iv = 1'b0; layer_info_iv = 1'b0;
        for (int k = 1; k <= heff; k++) begin
            checks++;
            if (sa_w_ov !== 1'b1) begin
                errors++;
                $display("FAIL w_vld cycle t+%0d: got %b want 1", k, sa_w_ov);
            end
            if (inject && k == 1) begin
                start_iv  = 1'b1;
                weight_iv = 1'b1;
                weight_id = {64{8'hEE}};
            end
            @(negedge clk);
            start_iv = 1'b0; weight_iv = 1'b0;
        end
        checks++;
        if ({sa_w_ov, sa_bias_ov} !== 2'b01) begin
            errors++;
            $display("FAIL bias_slot t+%0d: w_vld,bias_vld=%b want 01", heff + 1, {sa_w_ov, sa_bias_ov});
        end
        @(negedge clk);
        checks++;
        if ({sa_bias_ov, sa_start_ov, busy_od} !== 3'b011) begin
            errors++;
            $display("FAIL start_slot t+%0d: bias,start,busy=%b want 011", heff + 2,
                     {sa_bias_ov, sa_start_ov, busy_od});
        end
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            checks++;
            if ({sa_start_ov, done_od, busy_od} !== 3'b001) begin
                errors++;
                $display("FAIL compute_wait %0d: start,done,busy=%b want 001", k,
                         {sa_start_ov, done_od, busy_od});
            end
        end
        sa_done_iv = 1'b1;
        @(negedge clk);
        sa_done_iv = 1'b0;
        checks++;
        if ({done_od, busy_od} !== 2'b11) begin
            errors++;
            $display("FAIL done_pulse: done,busy=%b want 11", {done_od, busy_od});
        end
        @(negedge clk);
        checks++;
        if ({done_od, busy_od} !== 2'b00) begin
            errors++;
            $display("FAIL after_done: done,busy=%b want 00", {done_od, busy_od});
        end
        checks++;
        if (exp_rows.size() != 0 || exp_bias.size() != 0) begin
            errors++;
            $display("FAIL leftover: rows=%0d bias=%0d want 0 0", exp_rows.size(), exp_bias.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({sa_w_ov, sa_bias_ov, sa_start_ov, done_od, busy_od, overrun_od} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {sa_w_ov, sa_bias_ov, sa_start_ov, done_od, busy_od, overrun_od});
        end
        checks++;
        if (sa_w_row_od !== '0 || sa_bias_od !== '0) begin
            errors++;
            $display("FAIL reset_data: row=%h bias=%h want 0", sa_w_row_od, sa_bias_od);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_mul();
        row_t r2;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mw[i][j] = 8'(8 * i + j);
        for (int j = 0; j < 8; j++) mb[j] = 8'(j + 1);
        load(3, 4, 8, MUL);
        push_expect(3);
        r2 = '0;
        r2[0] = 8'd16; r2[1] = 8'd17; r2[2] = 8'd18; r2[3] = 8'd19;
        checks++;
        if (exp_rows[0] !== r2) begin
            errors++;
            $display("FAIL model_row2: got %h want %h", exp_rows[0], r2);
        end
        run(3, 2, 1'b0);
        checks++;
        if (sa_w_row_od !== last_row || sa_bias_od !== last_bias) begin
            errors++;
            $display("FAIL hold: row=%h bias=%h want %h %h", sa_w_row_od, sa_bias_od, last_row, last_bias);
        end
    endtask

    task automatic test_back_to_back();
        push_expect(3);
        run(3, 0, 1'b0);
    endtask

    task automatic test_conv_bias();
        row_t e;
        for (int j = 0; j < 8; j++) mb[j] = 8'h11;
        mb[0] = 8'h7F;
        load(2, 8, 1, CONV);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mw[i][j] = 8'(8'hA0 + 8 * i + j);
        drive_bus();
        weight_iv = 1'b1;
        push_expect(2);
        run(2, 1, 1'b0);
        e = {8{8'h7F}};
        checks++;
        if (sa_bias_od !== e) begin
            errors++;
            $display("FAIL conv_broadcast: got %h want %h", sa_bias_od, e);
        end
    endtask

    task automatic test_mul_mask();
        row_t e;
        for (int j = 0; j < 8; j++) mb[j] = 8'd5;
        load(1, 8, 2, MUL);
        push_expect(1);
        run(1, 3, 1'b0);
        e = '0;
        e[0] = 8'd5; e[1] = 8'd5;
        checks++;
        if (sa_bias_od !== e) begin
            errors++;
            $display("FAIL mul_mask: got %h want %h", sa_bias_od, e);
        end
    endtask

    task automatic test_edge_heights();
        load(0, 8, 8, MUL);
        push_expect(0);
        run(0, 1, 1'b0);
        load(12, 8, 8, MUL);
        push_expect(8);
        run(8, 0, 1'b0);
    endtask

    task automatic test_protocol();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mw[i][j] = 8'(8'h30 + 8 * i + j);
        load(4, 6, 8, MUL);
        checks++;
        if (overrun_od !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b want 0", overrun_od);
        end
        push_expect(4);
        run(4, 1, 1'b1);
        checks++;
        if (overrun_od !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b want 1", overrun_od);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({overrun_od, busy_od} !== 2'b10) begin
            errors++;
            $display("FAIL overrun_sticky: overrun,busy=%b want 10", {overrun_od, busy_od});
        end
        test_reset();
    endtask

    task automatic test_reset_mid();
        load(1, 8, 8, MUL);
        push_expect(1);
        start_iv = 1'b1;
        @(negedge clk);
        start_iv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sa_start_ov !== 1'b1) begin
            errors++;
            $display("FAIL mid_start: got %b want 1", sa_start_ov);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({sa_w_ov, sa_bias_ov, sa_start_ov, done_od, busy_od, overrun_od} !== 6'b0
            || sa_w_row_od !== '0 || sa_bias_od !== '0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b row=%h bias=%h want all 0",
                     {sa_w_ov, sa_bias_ov, sa_start_ov, done_od, busy_od, overrun_od},
                     sa_w_row_od, sa_bias_od);
        end
        sa_done_iv = 1'b1;
        @(negedge clk);
        sa_done_iv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({done_od, busy_od} !== 2'b00) begin
                errors++;
                $display("FAIL stale_done %0d: done,busy=%b want 00", k, {done_od, busy_od});
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        weight_iv = 1'b0; bias_iv = 1'b0; layer_info_iv = 1'b0;
        start_iv = 1'b0; sa_done_iv = 1'b0;
        weight_id = '0; bias_id = '0;
        weight_height_id = '0; weight_width_id = '0; bias_width_id = '0; op_id = '0;
        m_ww = 0; m_bw = 0; m_op = 1'b0;
        last_row = '0; last_bias = '0;
        for (int i = 0; i < 8; i++) begin
            mb[i] = 8'h00;
            for (int j = 0; j < 8; j++) mw[i][j] = 8'h00;
        end
        @(negedge clk);
        test_reset();
        test_basic_mul();
        test_back_to_back();
        test_conv_bias();
        test_mul_mask();
        test_edge_heights();
        test_protocol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
